// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: eight logic ops on WIDTH-bit operands,
// CHUNK bits per clock (LSB first), with registered zero/parity flags.

module slu_chunk_op #(
   parameter int W = 8
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   always_comb begin
      y = a;
      case (op)
         3'b000: y = a & b;
         3'b001: y = a | b;
         3'b010: y = a ^ b;
         3'b011: y = ~(a | b);
         3'b100: y = ~(a ^ b);
         3'b101: y = a & ~b;
         3'b110: y = ~a;
         default: y = a;
      endcase
   end
endmodule

module serial_logic_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             parity,
   output logic             busy,
   output logic             done
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             zero_acc, par_acc;
   logic [CHUNK-1:0] a_c, b_c, chunk;
   logic             last, accept;
   logic             zero_nx, par_nx;

   assign a_c    = a_q[cnt*CHUNK +: CHUNK];
   assign b_c    = b_q[cnt*CHUNK +: CHUNK];
   assign last   = (cnt == CW'(N - 1));
   assign accept = start && (state != S_RUN);

   slu_chunk_op #(.W(CHUNK)) u_op (
      .op (op_q),
      .a  (a_c),
      .b  (b_c),
      .y  (chunk)
   );

   // Result with the current chunk merged in; on the last cycle this is the final value.
   always_comb begin
      res_nx = res_q;
      res_nx[cnt*CHUNK +: CHUNK] = chunk;
   end

   assign zero_nx = zero_acc & ~(|chunk);
   assign par_nx  = par_acc ^ (^chunk);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: state_nx = start ? S_RUN : S_IDLE;
         S_RUN:          state_nx = last ? S_DONE : S_RUN;
         default:        state_nx = S_IDLE;
      endcase
   end

   // busy/done are registered from the next state so no output is combinational.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx == S_RUN);
         done  <= (state_nx == S_DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         res_q    <= '0;
         cnt      <= '0;
         zero_acc <= 1'b1;
         par_acc  <= 1'b0;
         out      <= '0;
         zero     <= 1'b1;
         parity   <= 1'b0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         op_q     <= op;
         cnt      <= '0;
         zero_acc <= 1'b1;
         par_acc  <= 1'b0;
      end else if (state == S_RUN) begin
         res_q    <= res_nx;
         zero_acc <= zero_nx;
         par_acc  <= par_nx;
         if (last) begin
            out    <= res_nx;
            zero   <= zero_nx;
            parity <= par_nx;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit at 32/8, 16/16 and 64/4 configurations.

module tb_serial_logic_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        s32_start = 1'b0;
   logic [2:0]  s32_op = '0;
   logic [31:0] s32_a = '0, s32_b = '0, s32_out;
   logic        s32_zero, s32_parity, s32_busy, s32_done;

   logic        s16_start = 1'b0;
   logic [2:0]  s16_op = '0;
   logic [15:0] s16_a = '0, s16_b = '0, s16_out;
   logic        s16_zero, s16_parity, s16_busy, s16_done;

   logic        s64_start = 1'b0;
   logic [2:0]  s64_op = '0;
   logic [63:0] s64_a = '0, s64_b = '0, s64_out;
   logic        s64_zero, s64_parity, s64_busy, s64_done;

   serial_logic_unit #(.WIDTH(32), .CHUNK(8)) dut32 (
      .clk(clk), .rst(rst), .start(s32_start), .op(s32_op), .a(s32_a), .b(s32_b),
      .out(s32_out), .zero(s32_zero), .parity(s32_parity), .busy(s32_busy), .done(s32_done));
   serial_logic_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst(rst), .start(s16_start), .op(s16_op), .a(s16_a), .b(s16_b),
      .out(s16_out), .zero(s16_zero), .parity(s16_parity), .busy(s16_busy), .done(s16_done));
   serial_logic_unit #(.WIDTH(64), .CHUNK(4)) dut64 (
      .clk(clk), .rst(rst), .start(s64_start), .op(s64_op), .a(s64_a), .b(s64_b),
      .out(s64_out), .zero(s64_zero), .parity(s64_parity), .busy(s64_busy), .done(s64_done));

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] out;
      logic        zero;
      logic        parity;
      int          cyc;
   } exp_t;

   exp_t q32[$], q16[$], q64[$];
   int cyc = 0;
   int npass = 0;
   int ntot = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      ntot++;
      if (act === req) npass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endfunction

   function automatic logic [63:0] ref_op(logic [2:0] op, logic [63:0] a, logic [63:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a | b);
         3'd4: return ~(a ^ b);
         3'd5: return a & ~b;
         3'd6: return ~a;
         default: return a;
      endcase
   endfunction

   function automatic logic done_of(int sel);
      case (sel)
         32: return s32_done;
         16: return s16_done;
         default: return s64_done;
      endcase
   endfunction

   // Issue one operation at the current (negedge) time and record what must come back.
   task automatic drive(int sel, logic [2:0] op, logic [63:0] a, logic [63:0] b, logic [63:0] res);
      exp_t e;
      e.out = res;
      e.zero = (res == 64'd0);
      e.parity = ^res;
      case (sel)
         32: begin
            s32_start = 1'b1; s32_op = op; s32_a = a[31:0]; s32_b = b[31:0];
            e.cyc = cyc + 1 + 4; q32.push_back(e);
         end
         16: begin
            s16_start = 1'b1; s16_op = op; s16_a = a[15:0]; s16_b = b[15:0];
            e.cyc = cyc + 1 + 1; q16.push_back(e);
         end
         default: begin
            s64_start = 1'b1; s64_op = op; s64_a = a; s64_b = b;
            e.cyc = cyc + 1 + 16; q64.push_back(e);
         end
      endcase
      @(negedge clk);
      s32_start = 1'b0;
      s16_start = 1'b0;
      s64_start = 1'b0;
   endtask

   task automatic wait_done(int sel, int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = done_of(sel);
      end
      if (!got) check($sformatf("timeout_done_%0d", sel), 64'(got), 64'd1);
   endtask

   task automatic mon(int sel, logic [63:0] o, logic z, logic p, logic bz, logic d);
      exp_t e;
      bit have = 1'b0;
      case (sel)
         32: if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
         16: if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
         default: if (q64.size() > 0) begin e = q64.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         check($sformatf("unexpected_done_%0d", sel), 64'(d), 64'd0);
      end else begin
         check($sformatf("out_%0d", sel), o, e.out);
         check($sformatf("zero_%0d", sel), 64'(z), 64'(e.zero));
         check($sformatf("parity_%0d", sel), 64'(p), 64'(e.parity));
         check($sformatf("done_cycle_%0d", sel), 64'(cyc), 64'(e.cyc));
         check($sformatf("busy_in_done_%0d", sel), 64'(bz), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (s32_done === 1'b1) mon(32, {32'd0, s32_out}, s32_zero, s32_parity, s32_busy, s32_done);
      if (s16_done === 1'b1) mon(16, {48'd0, s16_out}, s16_zero, s16_parity, s16_busy, s16_done);
      if (s64_done === 1'b1) mon(64, s64_out, s64_zero, s64_parity, s64_busy, s64_done);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      logic [2:0]  rop;
      logic [63:0] ra, rb;

      // Asynchronous reset between edges, before any clock edge has occurred.
      #3 rst = 1'b1;
      #1;
      check("rst_out", {32'd0, s32_out}, 64'd0);
      check("rst_zero", 64'(s32_zero), 64'd1);
      check("rst_parity", 64'(s32_parity), 64'd0);
      check("rst_busy", 64'(s32_busy), 64'd0);
      check("rst_done", 64'(s32_done), 64'd0);
      check("rst_out64", s64_out, 64'd0);
      @(negedge clk) rst = 1'b0;

      // XOR with busy length and held output
      @(negedge clk);
      drive(32, 3'b010, 64'hFFFF0000, 64'h0F0F0F0F, 64'hF0F00F0F);
      nb = 0;
      for (int i = 0; i < 20 && s32_busy; i++) begin
         nb++;
         check("out_held_in_run", {32'd0, s32_out}, 64'd0);
         @(negedge clk);
      end
      check("busy_cycles", 64'(nb), 64'd4);

      // zero / parity flags
      @(negedge clk); drive(32, 3'b010, 64'h12345678, 64'h12345678, 64'h0);        wait_done(32, 10);
      @(negedge clk); drive(32, 3'b000, 64'h00000001, 64'hFFFFFFFF, 64'h00000001); wait_done(32, 10);
      @(negedge clk); drive(32, 3'b110, 64'h00000000, 64'h0,        64'hFFFFFFFF); wait_done(32, 10);

      // start/operand changes while busy are ignored; start in DONE is accepted
      @(negedge clk); drive(32, 3'b001, 64'h1, 64'h2, 64'h3);
      for (int i = 0; i < 3; i++) begin
         s32_start = 1'b1; s32_op = 3'b000;
         s32_a = $urandom; s32_b = $urandom;
         @(negedge clk);
      end
      s32_start = 1'b0;
      s32_a = 32'hDEADBEEF;
      wait_done(32, 10);
      drive(32, 3'b111, 64'hCAFEBABE, 64'h0, 64'hCAFEBABE);
      wait_done(32, 10);

      // reset in the middle of an operation
      @(negedge clk);
      s32_start = 1'b1; s32_op = 3'b010; s32_a = 32'hFFFF0000; s32_b = 32'h0F0F0F0F;
      @(negedge clk) s32_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(s32_busy), 64'd0);
      check("abort_out", {32'd0, s32_out}, 64'd0);
      check("abort_zero", 64'(s32_zero), 64'd1);
      check("abort_parity", 64'(s32_parity), 64'd0);
      check("abort_done", 64'(s32_done), 64'd0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no_done_after_abort", 64'(s32_done), 64'd0);
      end
      @(negedge clk); drive(32, 3'b010, 64'hFFFF0000, 64'h0F0F0F0F, 64'hF0F00F0F); wait_done(32, 10);

      // single-chunk configuration
      @(negedge clk); drive(16, 3'b101, 64'hFF00, 64'h0F0F, 64'hF000); wait_done(16, 5);
      @(negedge clk); drive(16, 3'b011, 64'h0000, 64'h0001, 64'hFFFE); wait_done(16, 5);
      @(negedge clk); drive(16, 3'b000, 64'hFF00, 64'h00FF, 64'h0000); wait_done(16, 5);
      @(negedge clk); drive(16, 3'b100, 64'hA5A5, 64'hA5A5, 64'hFFFF); wait_done(16, 5);

      // 64/4: one directed op then back-to-back random ops issued in each DONE cycle
      @(negedge clk);
      drive(64, 3'b010, 64'hFFFFFFFF_00000000, 64'h01234567_89ABCDEF, 64'hFEDCBA98_89ABCDEF);
      wait_done(64, 30);
      for (int i = 0; i < 1000; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         drive(64, rop, ra, rb, ref_op(rop, ra, rb));
         wait_done(64, 30);
      end

      repeat (3) @(negedge clk);
      check("q32_drained", 64'(q32.size()), 64'd0);
      check("q16_drained", 64'(q16.size()), 64'd0);
      check("q64_drained", 64'(q64.size()), 64'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
